// File: rtl/wired_bus_arbiter_pkg.sv
// Shared types for the wired-bus arbiter: FSM states, index-width helper and owner index type.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    TURN
  } state_t;

  localparam int unsigned MAX_REQ = 8;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [$clog2(MAX_REQ)-1:0] owner_idx_t;

endpackage

// File: rtl/wired_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IW = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] winner,
  output logic [IW-1:0]    winner_idx,
  output logic             any
);

  int unsigned k;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    any        = 1'b0;
    k          = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = (32'(ptr) + i) % N_REQ;
      if (!any && req[k]) begin
        any        = 1'b1;
        winner[k]  = 1'b1;
        winner_idx = IW'(k);
      end
    end
  end

endmodule

// File: rtl/wired_bus_arbiter.sv
// Round-robin owner sequencer for a shared wired bus, with a dead TURN cycle between owners.
// Optional owner-idle watchdog enabled by defining WIRED_BUS_ARB_WATCHDOG_EN.
module wired_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned TIMEOUT  = 31
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          last,
  input  logic [N_REQ-1:0]          valid_in,
  input  logic [N_REQ*DATA_W-1:0]   data_in,
  output logic [N_REQ-1:0]          gnt,
  output logic [idx_w(N_REQ)-1:0]   owner,
  output logic [DATA_W-1:0]         bus_data,
  output logic                      bus_valid,
  output logic                      busy,
  output logic                      err
);

  localparam int unsigned IW = idx_w(N_REQ);
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  if (N_REQ < 2 || N_REQ > MAX_REQ || MAX_HOLD < 1 || MAX_HOLD > 255 || TIMEOUT < 1)
  begin : g_bad_param
    $error("wired_bus_arbiter: parameter out of range");
  end

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [HW-1:0]     hold_q, hold_d;

  logic [N_REQ-1:0]  pick_win;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic              own_req, own_last, own_valid, wd_trip, release_w;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (req),
    .ptr        (ptr_q),
    .winner     (pick_win),
    .winner_idx (pick_idx),
    .any        (pick_any)
  );

  assign own_req   = req[owner_q];
  assign own_last  = last[owner_q];
  assign own_valid = valid_in[owner_q];

`ifdef WIRED_BUS_ARB_WATCHDOG_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] idle_q, idle_d;
  logic          err_q, err_d;

  always_comb begin
    wd_trip = (state_q == OWN) && !own_valid && (idle_q == CW'(TIMEOUT - 1));
    idle_d  = '0;
    if (state_q == OWN && !own_valid) begin
      idle_d = (idle_q == '1) ? idle_q : idle_q + 1'b1;
    end
    err_d = err_q | wd_trip;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
      err_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign wd_trip = 1'b0;
  assign err     = 1'b0;
`endif

  // last and !req may coincide; they collapse into one release decision.
  assign release_w = (own_last && own_valid) || !own_req ||
                     (hold_q == HW'(MAX_HOLD - 1)) || wd_trip;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE, TURN: begin
        gnt_d   = '0;
        owner_d = '0;
        hold_d  = '0;
        state_d = IDLE;
        if (pick_any) begin
          state_d = OWN;
          gnt_d   = pick_win;
          owner_d = pick_idx;
        end
      end
      OWN: begin
        if (release_w) begin
          state_d = TURN;
          gnt_d   = '0;
          owner_d = '0;
          hold_d  = '0;
          ptr_d   = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        end else if (hold_q != '1) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);
  assign bus_valid = (state_q == OWN) && own_valid;
  assign bus_data  = bus_valid ? data_in[32'(owner_q)*DATA_W +: DATA_W] : '0;

endmodule

// File: doc/wired_bus_arbiter.md
# wired_bus_arbiter

Round-robin arbiter and sequencer for a shared multi-driver net bus. The bus is a wired bundle (wand/triand/tri nets) reached from several module instances. It grants at most one requester at a time, bounds ownership length, and inserts one dead turnaround cycle between owners so two drivers never contend. The block sits beside the shared net and feeds per-requester output enables to the driving instances.

## Interface
- N_REQ, 4: number of requesters, 2..8
- DATA_W, 8: bus data width
- MAX_HOLD, 15: maximum ownership cycles before forced release, 1..255
- TIMEOUT, 31: cycles an owner may hold without asserting valid (macro feature only)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester request, level
- last  in  N_REQ  owner's final beat; sampled only for the current owner
- valid_in  in  N_REQ  per-requester beat valid
- data_in  in  N_REQ×DATA_W  per-requester data, packed
- gnt  out  N_REQ  one-hot grant / output enable
- owner  out  $clog2(N_REQ)  index of current owner, 0 when none
- bus_data  out  DATA_W  data_in[owner] when a beat is valid, else 0
- bus_valid  out  1  granted owner's valid_in
- busy  out  1  state ≠ IDLE
- err  out  1  sticky watchdog flag (0 when macro absent)

## Operation
- States (bus_arb_pkg::state_t): IDLE, OWN, TURN.
- IDLE: if any req, pick via round-robin from pointer ptr. Winner is the first requester with req set at index ≥ ptr, wrapping. Next state OWN with gnt[winner]. Otherwise stay IDLE.
- OWN: hold_cnt increments every cycle, starting at 0 on entry. Release when any of these holds:
  - last[owner] && valid_in[owner]
  - !req[owner]
  - hold_cnt == MAX_HOLD-1
- On release: next state TURN, ptr ← owner+1 mod N_REQ.
- TURN: all gnt low, bus_valid 0. Arbitrate exactly as IDLE, using the updated ptr. Next state OWN if any req, else IDLE.
- A requester that was force-released may win again only after the lower-priority requesters in the rotation.
- bus_data/bus_valid are combinational from the registered gnt. Non-owner valid_in and last are ignored.
- hold_cnt is $clog2(MAX_HOLD+1) bits and saturates; it never wraps.

## Timing
- Reset values: gnt=0, owner=0, bus_valid=0, bus_data=0, busy=0, err=0, ptr=0, state IDLE, hold_cnt=0.
- Grant latency: req rising in IDLE at edge t gives gnt at t+1.
- Handover: release decided in cycle c means cycle c+1 is TURN with all gnt low; the next gnt appears at c+2. The minimum gap between owners is exactly 1 cycle.
- Simultaneous requests: round-robin order from ptr; ptr updates only on release.
- Owner drops req while also asserting last: a single release, no double counting.
- rst asserted mid-ownership: at the next edge all outputs return to reset values. No TURN cycle is inserted.
- Single requester with req held continuously: pattern is MAX_HOLD OWN cycles, 1 TURN cycle, repeat.

## Configuration
- WIRED_BUS_ARB_WATCHDOG_EN defined:
  - In OWN, idle_cnt counts consecutive cycles with !valid_in[owner].
  - When idle_cnt reaches TIMEOUT, the owner is force-released through TURN and err sets.
  - err clears only on rst.
- Macro absent: no idle_cnt logic; err tied 0; TIMEOUT unused.

## Structure
- Package bus_arb_pkg: state_t enum (IDLE, OWN, TURN), a function returning the index width for N_REQ, and an owner-index typedef.
- Sub-module rr_pick (combinational): inputs req and ptr; outputs one-hot winner, winner index and any. It is instantiated once and used in both IDLE and TURN.

## Test plan
- N_REQ=4, reset, then req=4'b0100 → gnt=4'b0100 one cycle later, owner=2, busy=1.
- req=4'b1111, each owner asserts last on its first valid beat → grant order 0,1,2,3,0. Each grant is separated by exactly one cycle with gnt=0.
- MAX_HOLD=15, req[1] held, no last → gnt[1] high for exactly 15 cycles, then 1 low cycle, then re-granted.
- Owner 3 with valid_in[3]=1, data_in[3]=8'hA5, valid_in[0]=1, data_in[0]=8'h3C → bus_data=8'hA5. When owner is 3 and valid_in[3]=0, bus_data=0 and bus_valid=0.
- rst pulsed while owner=2 mid-burst → next cycle gnt=0, owner=0, busy=0. A subsequent req=4'b0110 grants requester 1 (ptr reset to 0).
- With WIRED_BUS_ARB_WATCHDOG_EN and TIMEOUT=31, owner holds req with valid_in=0 → release after 31 cycles, err=1 and stays 1 until rst.
